// File: rtl/prefetch_queue.sv
// prefetch_queue: in-order fetch FIFO that streams sequential addresses from memory,
// with flush redirect, bus hold and a registered head entry.
module prefetch_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     ph1,
  input  logic                     reset,
  output logic [ADDR_WIDTH-1:0]    address,
  output logic                     read_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     mem_ready,
  input  logic                     hold,
  input  logic                     flush,
  input  logic [ADDR_WIDTH-1:0]    flush_addr,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    head_data,
  output logic [ADDR_WIDTH-1:0]    head_pc,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] fpc;
  logic [PW-1:0] head, tail;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic push, pop_ok;
  // state resets asynchronously, so read_en drops the instant reset asserts
  assign read_en = state == RUN && count != FULL && !hold && !flush;
  assign push = read_en && mem_ready;
  assign pop_ok = pop && count != '0 && !flush;
  assign address = fpc;
  assign head_valid = count != '0;
  assign head_data = data_mem[head];
  assign head_pc = pc_mem[head];
  always_ff @(posedge ph1 or negedge reset)
    if (!reset) begin
      state <= IDLE;
      fpc <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      state <= RUN;
      fpc <= flush_addr;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fpc <= fpc + ADDR_WIDTH'(1);
        tail <= tail + PW'(1);
      end
      if (pop_ok) head <= head + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop_ok};
    end
  always_ff @(posedge ph1)
    if (push) begin
      data_mem[tail] <= data_in;
      pc_mem[tail] <= fpc;
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: randomized and directed stimulus checked against a queue-based model.
module tb_prefetch_queue;
  localparam int AW = 16, DW = 8, D = 4;
  logic ph1 = 1'b0, reset = 1'b0;
  logic [AW-1:0] address, flush_addr = '0, head_pc;
  logic read_en, mem_ready = 1'b0, hold = 1'b0, flush = 1'b0, pop = 1'b0, head_valid;
  logic [DW-1:0] data_in = '0, head_data;
  logic [$clog2(D):0] count;
  int checks = 0, errors = 0;
  logic [AW+DW-1:0] q[$];
  logic [AW-1:0] m_fpc = '0;
  logic m_run = 1'b0;

  prefetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .ph1(ph1), .reset(reset), .address(address), .read_en(read_en), .data_in(data_in),
    .mem_ready(mem_ready), .hold(hold), .flush(flush), .flush_addr(flush_addr), .pop(pop),
    .head_data(head_data), .head_pc(head_pc), .head_valid(head_valid), .count(count)
  );

  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic h, input logic f, input logic p, input logic mr,
                      input logic [AW-1:0] fa);
    logic exp_re;
    logic [AW+DW-1:0] e;
    @(negedge ph1);
    hold = h; flush = f; pop = p; mem_ready = mr; flush_addr = fa;
    data_in = DW'($urandom);
    #1;
    exp_re = m_run && q.size() < D && !h && !f;
    check("read_en", read_en, exp_re);
    check("address", address, m_fpc);
    check("count", count, q.size());
    check("head_valid", head_valid, q.size() != 0);
    if (q.size() != 0) begin
      e = q[0];
      check("head_pc", head_pc, e[AW+DW-1:DW]);
      check("head_data", head_data, e[DW-1:0]);
    end
    @(posedge ph1);
    if (f) begin
      q.delete();
      m_fpc = fa;
      m_run = 1'b1;
    end else begin
      if (p && q.size() != 0) void'(q.pop_front());
      if (exp_re && mr) begin
        q.push_back({m_fpc, data_in});
        m_fpc = m_fpc + 1'b1;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge ph1);
    #1;
    check("rst_read_en", read_en, 0);
    check("rst_count", count, 0);
    check("rst_head_valid", head_valid, 0);
    check("rst_address", address, 0);
    reset = 1'b1;
    repeat (3) step(0, 0, 0, 1, '0);
    step(0, 1, 0, 1, 16'hFFFC);
    repeat (5) step(0, 0, 0, 1, '0);
    #2;
    check("fill_count", count, 4);
    check("fill_read_en", read_en, 0);
    check("fill_head_pc", head_pc, 16'hFFFC);
    repeat (8) step(0, 0, 1, 1, '0);
    #2;
    check("steady_count", count, 3);
    step(0, 1, 0, 1, 16'h0100);
    repeat (2) step(0, 0, 0, 1, '0);
    step(0, 1, 1, 1, 16'h0200);
    #2;
    check("flush_count", count, 0);
    check("flush_head_valid", head_valid, 0);
    check("flush_address", address, 16'h0200);
    step(0, 0, 0, 1, '0);
    #2;
    check("flush_head_pc", head_pc, 16'h0200);
    repeat (3) step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0);
    #2;
    check("stall_count", count, 2);
    repeat (5) step(1, 0, 1, 1, '0);
    #2;
    check("hold_count", count, 0);
    check("hold_address", address, 16'h0202);
    step(0, 1, 0, 1, 16'h1234);
    @(negedge ph1);
    hold = 0; flush = 0; pop = 0; mem_ready = 1;
    #1;
    check("pre_rst_read_en", read_en, 1);
    #2 reset = 1'b0;
    #1;
    check("async_read_en", read_en, 0);
    check("async_count", count, 0);
    check("async_head_valid", head_valid, 0);
    check("async_address", address, 0);
    q.delete();
    m_fpc = '0;
    m_run = 1'b0;
    @(negedge ph1);
    reset = 1'b1;
    repeat (3) step(0, 0, 0, 1, '0);
    step(0, 1, 0, 1, AW'($urandom));
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7, AW'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of the fetch address and tag.
REQ-002 Parameter DATA_WIDTH, default 8, width of one fetched byte/word.
REQ-003 Parameter DEPTH, default 4, number of queue entries; legal values are powers of two from 2 to 16.
REQ-004 Port ph1  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port address  output  ADDR_WIDTH  memory fetch address; always equals the internal fetch pointer fpc.
REQ-007 Port read_en  output  1  fetch request to memory.
REQ-008 Port data_in  input  DATA_WIDTH  memory read data; valid in any cycle where read_en and mem_ready are both 1.
REQ-009 Port mem_ready  input  1  memory accepts and completes the current read this cycle.
REQ-010 Port hold  input  1  suspends fetching so the core can use the bus.
REQ-011 Port flush  input  1  discards the queue and redirects fetching.
REQ-012 Port flush_addr  input  ADDR_WIDTH  new fetch address, sampled when flush=1.
REQ-013 Port pop  input  1  the consumer takes the head entry.
REQ-014 Port head_data  output  DATA_WIDTH  data of the oldest entry.
REQ-015 Port head_pc  output  ADDR_WIDTH  address the head entry was fetched from.
REQ-016 Port head_valid  output  1  queue is non-empty.
REQ-017 Port count  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-018 The FSM SHALL have two states: IDLE (entered on reset) and RUN; IDLE->RUN occurs on flush=1; no transition leaves RUN except reset.
REQ-019 read_en SHALL be 1 only when state=RUN, count<DEPTH, hold=0 and flush=0; it is combinational from these signals.
REQ-020 A push occurs when read_en=1 and mem_ready=1: data_in and fpc are written at the tail, and fpc increments by 1 modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-021 When read_en=1 and mem_ready=0, the block SHALL hold address and keep read_en asserted; nothing is written.
REQ-022 A pop occurs when pop=1 and head_valid=1; pop while empty is ignored with no state change.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and advance both the head and tail pointers.
REQ-024 When full (count=DEPTH), read_en=0, so no push is possible; a pop in that cycle makes read_en eligible in the next cycle.
REQ-025 head_data, head_pc and head_valid SHALL be driven from registered queue state with no combinational path from data_in; a pushed entry becomes visible the cycle after the push.
REQ-026 Flush priority: when flush=1, any same-cycle push and pop are suppressed; next cycle count=0, head_valid=0, fpc=flush_addr, state=RUN.
REQ-027 Back-to-back flushes SHALL each reload fpc, and the last one wins.
REQ-028 hold=1 in RUN SHALL freeze fpc and block pushes; pops remain permitted.
REQ-029 The head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-030 While reset=0, regardless of ph1: state=IDLE, fpc=0, count=0, head/tail pointers=0, head_valid=0, read_en=0, address=0.
REQ-031 Queue storage is not reset; head_data and head_pc are don't-care while head_valid=0.
REQ-032 A reset assertion mid-fetch SHALL abandon the outstanding request immediately (read_en=0 asynchronously).
REQ-033 After reset is released, no fetch occurs until the first flush.

Verification
REQ-034 Reset, then flush with flush_addr=16'hFFFC, mem_ready=1, no pops, DEPTH=4 -> addresses FFFC, FFFD, FFFE, FFFF are fetched, then read_en=0 and count=4; head_pc=FFFC.
REQ-035 Continuing from REQ-034, pop once per cycle with mem_ready=1 -> the next fetch address is 16'h0000 (wrap-around), count holds at 3 in steady state, and head_pc sequence is FFFC, FFFD, ...
REQ-036 Queue at count=2, assert flush=1 with pop=1 and a push in the same cycle, flush_addr=16'h0200 -> next cycle count=0, head_valid=0, address=0200; the first entry after that has head_pc=0200.
REQ-037 RUN with mem_ready=0 for 3 cycles, then 1 -> address is stable for all 4 cycles and exactly one entry is pushed.
REQ-038 hold=1 for 5 cycles with count=2, pop=1 each cycle -> read_en=0 throughout, count goes 2, 1, 0 and stays 0, fpc is unchanged.
REQ-039 Assert reset=0 asynchronously mid-cycle while read_en=1 -> read_en, count and head_valid go to 0 before the next ph1 edge; no fetch occurs until a flush.
